// File: rtl/regfile_param.sv
// regfile_param: parametrised multi-read-port register file with a reset-time clearing sweep.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding (write-first reads).
module regfile_param #(
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [ADDR_W-1:0]       waddr,
    input  logic [DATA_W-1:0]       wdata,
    input  logic [NRD*ADDR_W-1:0]   raddr,
    output logic [NRD*DATA_W-1:0]   rdata,
    output logic                    ready
);

    typedef enum logic [1:0] {
        ST_RESET,
        ST_INIT,
        ST_RUN
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W:0]     idx;
    logic                sweep_en;
    logic                wr_en;
    logic [DATA_W-1:0]   mem [DEPTH];

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH_C) && !(ZERO_REG != 0 && a == '0);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RESET;
        end else begin
            state <= state_nxt;
        end
    end

    // The first edge out of RESET already clears entry 0, so RESET sweeps like INIT.
    always_comb begin
        state_nxt = state;
        sweep_en  = 1'b0;
        case (state)
            ST_RESET: begin
                sweep_en  = 1'b1;
                state_nxt = ST_INIT;
            end
            ST_INIT: begin
                sweep_en = 1'b1;
                if (idx == LAST_IDX) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                state_nxt = ST_RUN;
            end
            default: begin
                state_nxt = ST_RESET;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
        end else if (sweep_en) begin
            idx <= idx + 1'b1;
        end
    end

    assign ready = (state == ST_RUN);
    assign wr_en = !rst && ready && we && addr_ok(waddr);

    always_ff @(posedge clk) begin
        if (!rst && sweep_en) begin
            mem[idx[ADDR_W-1:0]] <= '0;
        end else if (wr_en) begin
            mem[waddr] <= wdata;
        end
    end

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;

        assign ra = raddr[g*ADDR_W +: ADDR_W];

        always_comb begin
            rd = '0;
            if (ready && addr_ok(ra)) begin
                rd = mem[ra];
`ifdef REGFILE_BYPASS_EN
                if (we && waddr == ra) begin
                    rd = wdata;
                end
`endif
            end
        end

        assign rdata[g*DATA_W +: DATA_W] = rd;
    end

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: default instance (32x16, 2 ports) and a
// 24x32, 4-port instance sharing clock and reset; reads are checked through a scoreboard.
module tb_regfile_param;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         a_we;
    logic [4:0]   a_waddr;
    logic [15:0]  a_wdata;
    logic [9:0]   a_raddr;
    logic [31:0]  a_rdata;
    logic         a_ready;

    logic         b_we;
    logic [4:0]   b_waddr;
    logic [31:0]  b_wdata;
    logic [19:0]  b_raddr;
    logic [127:0] b_rdata;
    logic         b_ready;

    regfile_param #(.DATA_W(16), .DEPTH(32), .NRD(2), .ZERO_REG(1)) u_a (
        .clk(clk), .rst(rst), .we(a_we), .waddr(a_waddr), .wdata(a_wdata),
        .raddr(a_raddr), .rdata(a_rdata), .ready(a_ready)
    );

    regfile_param #(.DATA_W(32), .DEPTH(24), .NRD(4), .ZERO_REG(1)) u_b (
        .clk(clk), .rst(rst), .we(b_we), .waddr(b_waddr), .wdata(b_wdata),
        .raddr(b_raddr), .rdata(b_rdata), .ready(b_ready)
    );

    typedef struct {
        string       tag;
        bit          inst;
        int          port;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] a_mem [32];
    logic [31:0] b_mem [24];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_models();
        foreach (a_mem[i]) a_mem[i] = '0;
        foreach (b_mem[i]) b_mem[i] = '0;
    endtask

    function automatic logic [31:0] a_model(input logic [4:0] addr);
        if (addr == 5'd0) return 32'd0;
        return 32'(a_mem[addr]);
    endfunction

    function automatic logic [31:0] b_model(input logic [4:0] addr);
        if (addr == 5'd0 || addr >= 5'd24) return 32'd0;
        return b_mem[addr];
    endfunction

    task automatic exp_a(input int p, input logic [4:0] addr, input logic [31:0] exp, input string tag);
        exp_t e;
        a_raddr[p*5 +: 5] = addr;
        e = '{tag: tag, inst: 1'b0, port: p, exp: exp};
        sb.push_back(e);
    endtask

    task automatic exp_b(input int p, input logic [4:0] addr, input logic [31:0] exp, input string tag);
        exp_t e;
        b_raddr[p*5 +: 5] = addr;
        e = '{tag: tag, inst: 1'b1, port: p, exp: exp};
        sb.push_back(e);
    endtask

    // Reads are combinational: let them settle, then retire every pending expectation.
    task automatic drain();
        exp_t        e;
        logic [31:0] got;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.inst) got = b_rdata[e.port*32 +: 32];
            else        got = 32'(a_rdata[e.port*16 +: 16]);
            check_eq(e.tag, got, e.exp);
        end
    endtask

    task automatic a_write(input logic [4:0] addr, input logic [15:0] data);
        a_we = 1'b1; a_waddr = addr; a_wdata = data;
        tick();
        a_we = 1'b0;
        if (addr != 5'd0) a_mem[addr] = data;
    endtask

    task automatic b_write(input logic [4:0] addr, input logic [31:0] data);
        b_we = 1'b1; b_waddr = addr; b_wdata = data;
        tick();
        b_we = 1'b0;
        if (addr != 5'd0 && addr < 5'd24) b_mem[addr] = data;
    endtask

    // Counts not-ready cycles from the current cycle on, bounded.
    task automatic count_ready(output int ca, output int cb);
        ca = 0;
        cb = 0;
        for (int c = 0; c < 100; c++) begin
            if (a_ready && b_ready) break;
            if (!a_ready) ca++;
            if (!b_ready) cb++;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ca, cb;
        rst = 1'b1;
        a_we = 1'b0; a_waddr = '0; a_wdata = '0; a_raddr = '0;
        b_we = 1'b0; b_waddr = '0; b_wdata = '0; b_raddr = '0;
        repeat (3) tick();

        // Reset state, then the full sweep
        exp_a(0, 5'd5, 32'd0, "rst_rd_a0");
        exp_a(1, 5'd31, 32'd0, "rst_rd_a1");
        exp_b(3, 5'd23, 32'd0, "rst_rd_b3");
        drain();
        check_eq("rst_ready_a", 32'(a_ready), 32'd0);
        check_eq("rst_ready_b", 32'(b_ready), 32'd0);
        rst = 1'b0;
        clear_models();
        count_ready(ca, cb);
        check_eq("sweep_len_a", ca, 32'd32);
        check_eq("sweep_len_b", cb, 32'd24);
        check_eq("ready_a", 32'(a_ready), 32'd1);

        // First ready cycle: write accepted immediately
        a_write(5'd5, 16'hBEEF);
        for (int i = 1; i < 32; i++) begin
            if (i != 5) begin
                exp_a(0, 5'(i), 32'd0, "sweep_zero");
                drain();
            end
        end
        exp_a(0, 5'd5, a_model(5'd5), "wr_rd_p0");
        exp_a(1, 5'd5, a_model(5'd5), "wr_rd_p1");
        drain();
        check_eq("model_beef", a_model(5'd5), 32'h0000BEEF);

        a_write(5'd0, 16'h1234);
        exp_a(0, 5'd0, 32'd0, "zero_reg");
        drain();

        // Same-cycle collision
        a_write(5'd7, 16'h0011);
        a_we = 1'b1; a_waddr = 5'd7; a_wdata = 16'h00AA;
`ifdef REGFILE_BYPASS_EN
        exp_a(1, 5'd7, 32'h00AA, "coll_same");
`else
        exp_a(1, 5'd7, 32'h0011, "coll_same");
`endif
        drain();
        tick();
        a_we = 1'b0;
        a_mem[7] = 16'h00AA;
        exp_a(1, 5'd7, a_model(5'd7), "coll_next");
        drain();

        // Forwarding never overrides the zero register
        a_we = 1'b1; a_waddr = 5'd0; a_wdata = 16'hFFFF;
        exp_a(0, 5'd0, 32'd0, "byp_zero");
        drain();
        tick();
        a_we = 1'b0;

        // Wide instance: out-of-range and four independent ports
        b_write(5'd30, 32'hDEADBEEF);
        b_write(5'd1,  32'h11111111);
        b_write(5'd7,  32'h77777777);
        b_write(5'd13, 32'hCAFEF00D);
        b_write(5'd23, 32'h23232323);
        exp_b(0, 5'd1,  b_model(5'd1),  "b_p0");
        exp_b(1, 5'd7,  b_model(5'd7),  "b_p1");
        exp_b(2, 5'd13, b_model(5'd13), "b_p2");
        exp_b(3, 5'd23, 32'h23232323,   "b_p3_last");
        drain();
        exp_b(0, 5'd30, 32'd0, "b_oor30");
        exp_b(1, 5'd24, 32'd0, "b_oor24");
        exp_b(2, 5'd0,  32'd0, "b_zero");
        drain();

        // Reset mid-sweep restarts it and discards old contents
        rst = 1'b1; tick(); rst = 1'b0;
        repeat (19) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        clear_models();
        count_ready(ca, cb);
        check_eq("restart_len_a", ca, 32'd32);
        check_eq("restart_len_b", cb, 32'd24);
        exp_a(0, 5'd5, a_model(5'd5), "restart_clr_a");
        exp_b(3, 5'd23, b_model(5'd23), "restart_clr_b");
        drain();

        // Writes during the sweep and in the last not-ready cycle are dropped
        rst = 1'b1; tick(); rst = 1'b0;
        clear_models();
        repeat (9) tick();
        a_we = 1'b1; a_waddr = 5'd3; a_wdata = 16'h5555;
        tick();
        a_we = 1'b0;
        repeat (21) tick();
        check_eq("late_not_ready", 32'(a_ready), 32'd0);
        a_we = 1'b1; a_waddr = 5'd4; a_wdata = 16'h4444;
        tick();
        a_we = 1'b0;
        check_eq("late_ready", 32'(a_ready), 32'd1);
        exp_a(0, 5'd3, 32'd0, "init_wr_drop");
        exp_a(1, 5'd4, 32'd0, "pre_ready_drop");
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
